// File: rtl/signal_jump_ctrl.sv
// Next-PC select decoder: registers a 2-bit jump decision from opcode and ALU flags.
// Latency: one cycle (decision for the edge-N inputs is visible after edge N); no backpressure, En gates capture.
module signal_jump_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       En,
  input  logic [4:0] Ins,
  input  logic       Zero,
  input  logic       Neg,
  output logic [1:0] Jump
);

  localparam logic [1:0] SEL_SEQ = 2'b00;
  localparam logic [1:0] SEL_REL = 2'b01;
  localparam logic [1:0] SEL_ABS = 2'b10;
  localparam logic [1:0] SEL_REG = 2'b11;

  logic [1:0] jump_nxt;

  // Branch conditions resolve to a taken/not-taken pick between REL and SEQ.
  always_comb begin
    jump_nxt = SEL_SEQ;
    case (Ins)
      5'b11000, 5'b11001: jump_nxt = SEL_ABS;
      5'b11010, 5'b11011: jump_nxt = SEL_REG;
      5'b11100:           jump_nxt = Zero  ? SEL_REL : SEL_SEQ;
      5'b11101:           jump_nxt = !Zero ? SEL_REL : SEL_SEQ;
      5'b11110:           jump_nxt = Neg   ? SEL_REL : SEL_SEQ;
      5'b11111:           jump_nxt = !Neg  ? SEL_REL : SEL_SEQ;
      default:            jump_nxt = SEL_SEQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      Jump <= SEL_SEQ;
    end else if (En) begin
      Jump <= jump_nxt;
    end
  end

endmodule

// File: tb/tb_signal_jump_ctrl.sv
// Directed bench for signal_jump_ctrl: hand-computed vectors, outputs sampled 1ns after the rising edge.
module tb_signal_jump_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       En;
  logic [4:0] Ins;
  logic       Zero;
  logic       Neg;
  logic [1:0] Jump;

  int n_checks = 0;
  int n_fail   = 0;

  signal_jump_ctrl dut (
    .clk  (clk),
    .rst  (rst),
    .En   (En),
    .Ins  (Ins),
    .Zero (Zero),
    .Neg  (Neg),
    .Jump (Jump)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Apply inputs mid-cycle, then step one rising edge and settle.
  task automatic step(input logic r, input logic e, input logic [4:0] i,
                      input logic z, input logic n);
    @(negedge clk);
    rst  = r;
    En   = e;
    Ins  = i;
    Zero = z;
    Neg  = n;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; En = 1'b0; Ins = 5'b0; Zero = 1'b0; Neg = 1'b0;

    // Reset overrides a capturing JMP.
    step(1, 1, 5'b11000, 0, 0); check("reset_jmp", Jump, 2'b00);
    step(1, 1, 5'b11010, 1, 1); check("reset_jr",  Jump, 2'b00);

    // Unconditional jumps.
    step(0, 1, 5'b11001, 0, 0); check("jal",  Jump, 2'b10);
    step(0, 1, 5'b11011, 1, 0); check("jalr", Jump, 2'b11);
    step(0, 1, 5'b11000, 1, 1); check("jmp",  Jump, 2'b10);
    step(0, 1, 5'b11010, 0, 1); check("jr",   Jump, 2'b11);

    // Conditional branches, full flag table.
    step(0, 1, 5'b11100, 1, 0); check("beqz_z1", Jump, 2'b01);
    step(0, 1, 5'b11100, 0, 0); check("beqz_z0", Jump, 2'b00);
    step(0, 1, 5'b11101, 0, 1); check("bnez_z0", Jump, 2'b01);
    step(0, 1, 5'b11101, 1, 0); check("bnez_z1", Jump, 2'b00);
    step(0, 1, 5'b11110, 0, 1); check("bltz_n1", Jump, 2'b01);
    step(0, 1, 5'b11110, 1, 0); check("bltz_n0", Jump, 2'b00);
    step(0, 1, 5'b11111, 0, 0); check("bgez_n0", Jump, 2'b01);
    step(0, 1, 5'b11111, 0, 1); check("bgez_n1", Jump, 2'b00);

    // Both flags set decode literally.
    step(0, 1, 5'b11100, 1, 1); check("beqz_zn", Jump, 2'b01);
    step(0, 1, 5'b11101, 1, 1); check("bnez_zn", Jump, 2'b00);
    step(0, 1, 5'b11110, 1, 1); check("bltz_zn", Jump, 2'b01);
    step(0, 1, 5'b11111, 1, 1); check("bgez_zn", Jump, 2'b00);

    // Hold while En is low.
    step(0, 1, 5'b11010, 0, 0); check("hold_cap", Jump, 2'b11);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 5'b00000, k[0], ~k[0]);
      check($sformatf("hold_%0d", k), Jump, 2'b11);
    end

    // Flags only matter on the capture edge.
    step(0, 1, 5'b11100, 1, 0); check("flag_cap", Jump, 2'b01);
    step(0, 0, 5'b11100, 0, 1); check("flag_late0", Jump, 2'b01);
    step(0, 0, 5'b11101, 0, 0); check("flag_late1", Jump, 2'b01);

    // Non-jump sweep; a JMP capture before each vector makes a stuck/held output visible.
    for (int op = 0; op < 24; op++) begin
      for (int f = 0; f < 4; f++) begin
        step(0, 1, 5'b11000, 0, 0);
        check("sweep_pre", Jump, 2'b10);
        step(0, 1, op[4:0], f[1], f[0]);
        check($sformatf("sweep_op%0d_f%0d", op, f), Jump, 2'b00);
      end
    end

    // Reset mid-operation, then release.
    step(0, 1, 5'b11000, 0, 0); check("mid_pre",   Jump, 2'b10);
    step(1, 1, 5'b11000, 0, 0); check("mid_rst",   Jump, 2'b00);
    step(0, 1, 5'b11000, 0, 0); check("mid_after", Jump, 2'b10);

    // Release with En low keeps the cleared value until the first capture.
    step(1, 0, 5'b11011, 0, 0); check("rst_en0",   Jump, 2'b00);
    step(0, 0, 5'b11011, 0, 0); check("rel_hold",  Jump, 2'b00);
    step(0, 1, 5'b11011, 0, 0); check("rel_cap",   Jump, 2'b11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/signal_jump_ctrl.md
SIGNAL_JUMP_CTRL -- requirements
Module: Signal_Jump

Interface
REQ-001 Ports SHALL be exactly as listed in REQ-002..REQ-007; one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 En  input  1  decode strobe; high = capture new jump decision this edge.
REQ-005 Ins  input  5 (bits [15:11])  opcode field of current instruction word.
REQ-006 Zero, Neg  input  1 each  ALU status flags (result zero / result negative) qualifying conditional branches.
REQ-007 Jump  output  2  registered next-PC select: 00 = PC+1 sequential, 01 = PC-relative branch taken, 10 = absolute immediate jump, 11 = jump via register.

Function
REQ-008 Jump SHALL be a register; no combinational path from any input to Jump.
REQ-009 Latency: decision for inputs sampled at edge N SHALL appear on Jump after edge N, held until the next capturing edge.
REQ-010 When En=0 and rst=0, Jump SHALL hold its previous value regardless of Ins/Zero/Neg.
REQ-011 When En=1 and rst=0, Jump SHALL load the decode of Ins, Zero and Neg per REQ-012..REQ-016.
REQ-012 Ins=11000 (JMP) or 11001 (JAL) -> 10, independent of flags.
REQ-013 Ins=11010 (JR) or 11011 (JALR) -> 11, independent of flags.
REQ-014 Ins=11100 (BEQZ) -> 01 if Zero=1 else 00; Ins=11101 (BNEZ) -> 01 if Zero=0 else 00.
REQ-015 Ins=11110 (BLTZ) -> 01 if Neg=1 else 00; Ins=11111 (BGEZ) -> 01 if Neg=0 else 00.
REQ-016 All other opcodes (0xxxx, 10xxx) -> 00; no opcode is illegal; X/undefined never produced.
REQ-017 Flags SHALL be sampled on the same edge as Ins; flag values at other edges SHALL have no effect.
REQ-018 Zero=1 and Neg=1 together SHALL be accepted and decoded literally per REQ-014/REQ-015 (no consistency check).
REQ-019 Decode table SHALL be a single case/lookup; RTL SHALL contain no other state than the 2-bit Jump register.

Reset
REQ-020 rst=1 at a rising edge SHALL force Jump=00, overriding En, Ins and flags.
REQ-021 Reset asserted mid-sequence (e.g. while Jump=10) SHALL clear Jump to 00 on that edge; first capture after release occurs on the first edge with rst=0 and En=1.
REQ-022 Before the first reset edge Jump is undefined; bench SHALL apply rst for at least one edge.

Verification
REQ-023 Reset: rst=1, En=1, Ins=11000 for one edge -> Jump=00.
REQ-024 Unconditional: rst=0, En=1, Ins=11001 -> Jump=10 after edge; Ins=11011 next edge -> Jump=11.
REQ-025 Conditional: En=1, Ins=11100, Zero=1 -> 01; Zero=0 -> 00; Ins=11111, Neg=0 -> 01; Neg=1 -> 00.
REQ-026 Hold: capture Ins=11010 (Jump=11), then En=0 with Ins=00000 for 3 edges -> Jump stays 11.
REQ-027 Non-jump sweep: En=1, Ins over all 0xxxx and 10xxx values, all flag combos -> Jump=00 every edge.
REQ-028 Reset mid-op: Jump=10, assert rst=1 with En=1, Ins=11000 -> Jump=00; deassert rst -> next edge Jump=10.
